// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-control sequencer.
//   state_t            : controller state encoding
//   DEFAULT_HALT_INSTR : instruction word treated as program end by default
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   clear : synchronous clear (wins over increment)
//   en    : counter enable
//   inc   : increment request, honoured only while en is high
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the mips core: holds the core in reset for
// RESET_CYCLES after start, lets it run while counting cycles, retired
// instructions and register-file writes, and stops on a halt instruction,
// a PC self-loop, or after MAX_CYCLES run cycles.
// Ports:
//   clk, reset          : clock and synchronous active-low reset
//   start               : begins a run (IDLE/HALTED/TIMEOUT only)
//   pc, instr, grf_we   : observed core state
//   core_reset          : active-high reset to the core
//   running/done/timeout: registered status flags
//   cycle_count, retired_count, wb_count : run statistics
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | after reset, core held in reset, waiting for start
// HOLD    | core held in reset for RESET_CYCLES cycles
// RUN     | core released, counters active, halt checks live
// HALTED  | program end seen, core frozen, counters held
// TIMEOUT | run-cycle limit reached, core frozen, counters held
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          PC_W         = 32,
    parameter int          CNT_W        = 32,
    parameter int          RESET_CYCLES = 2,
    parameter int          MAX_CYCLES   = 10000,
    parameter logic [31:0] HALT_INSTR   = DEFAULT_HALT_INSTR,
    parameter int          LOOP_REPEAT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      instr,
    input  logic             grf_we,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int RPT_W  = $clog2(LOOP_REPEAT) + 1;

    state_t            state;
    state_t            next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_inc;
    logic [PC_W-1:0]   prev_pc;
    logic              pc_same;
    logic              halt_hit;
    logic              cnt_clear;
    logic              run_en;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (run_en),
        .inc   (1'b1),
        .count (cycle_count)
    );

    // The halt cycle itself did not retire an instruction.
    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (run_en),
        .inc   (!halt_hit),
        .count (retired_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (run_en),
        .inc   (grf_we),
        .count (wb_count)
    );

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        run_en     = (state == ST_RUN);
        pc_same    = (pc == prev_pc);
        rpt_inc    = rpt_cnt + RPT_W'(1);
        // Self-loop fires when this cycle makes LOOP_REPEAT consecutive
        // cycles at the same PC (LOOP_REPEAT-1 repeats).
        halt_hit   = (state == ST_RUN) &&
                     ((instr == HALT_INSTR) ||
                      (pc_same && (rpt_inc == RPT_W'(LOOP_REPEAT - 1))));

        case (state)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (start) begin
                    next_state = ST_HOLD;
                    cnt_clear  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    next_state = ST_HALTED;
                end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: begin
                next_state = ST_IDLE;
                run_en     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            rpt_cnt    <= '0;
            prev_pc    <= '0;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= next_state;
            // Flags are decoded from next_state so they change on the same
            // edge as the state register.
            core_reset <= (next_state != ST_RUN);
            running    <= (next_state == ST_RUN);
            done       <= (next_state == ST_HALTED);
            timeout    <= (next_state == ST_TIMEOUT);

            if (cnt_clear) begin
                hold_cnt <= HOLD_W'(RESET_CYCLES - 1);
            end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (cnt_clear) begin
                rpt_cnt <= '0;
                prev_pc <= '0;
            end else if (state == ST_RUN) begin
                prev_pc <= pc;
                rpt_cnt <= pc_same ? rpt_inc : '0;
            end
        end
    end

endmodule
